// File: rtl/bayes_pkg.sv
// bayes_pkg: shared defaults, saturation constant and state type for the log-domain datapath
package bayes_pkg;
  localparam int LOG_M = 8;
  localparam int LOG_N_CLASS = 4;
  localparam logic [LOG_M-1:0] LOG_SAT = '1;
  typedef enum logic {COLLECT, EMIT} state_t;
endpackage

// File: rtl/log_normalizer_if.sv
// log_normalizer_if: score stream in, normalized stream out; winner present with LOG_NORM_WINNER_EN
interface log_normalizer_if import bayes_pkg::*; #(parameter int M = LOG_M, parameter int N_CLASS = LOG_N_CLASS);
  localparam int IW = $clog2(N_CLASS);
  logic in_valid;
  logic in_ready;
  logic [M-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [M-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic out_last;
  logic all_sat;
`ifdef LOG_NORM_WINNER_EN
  logic [IW-1:0] winner;
`endif
  modport master(output in_valid, in_data, out_ready,
                 input in_ready, out_valid, out_data, out_idx, out_last, all_sat
`ifdef LOG_NORM_WINNER_EN
                 , input winner
`endif
                 );
  modport slave(input in_valid, in_data, out_ready,
                output in_ready, out_valid, out_data, out_idx, out_last, all_sat
`ifdef LOG_NORM_WINNER_EN
                , output winner
`endif
                );
endinterface

// File: rtl/log_subtractor.sv
// log_subtractor: saturating log-domain subtract, a-b clamped at 0, saturated a passes through
module log_subtractor #(parameter int M = 8) (
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  output logic [M-1:0] y_o
);
  // saturated scores stay impossible; otherwise subtract without wrapping below zero
  always_comb y_o = &a_i ? a_i : (a_i < b_i ? '0 : a_i - b_i);
endmodule

// File: rtl/log_normalizer.sv
// log_normalizer: collects a frame of log scores and re-emits them minus the frame minimum; winner output with LOG_NORM_WINNER_EN
module log_normalizer import bayes_pkg::*; #(
  parameter int M = LOG_M,
  parameter int N_CLASS = LOG_N_CLASS
) (
  input logic clk,
  input logic rst,
  log_normalizer_if.slave bus
);
  localparam int IW = $clog2(N_CLASS);
  localparam logic [IW-1:0] LAST = IW'(N_CLASS - 1);
  localparam logic [M-1:0] SAT = '1;
  state_t state_q, state_d;
  logic [IW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [M-1:0] min_q, min_d, diff;
  logic all_sat_q, all_sat_d;
  logic [M-1:0] buf_q [N_CLASS];
  logic acc, fire, lt;
  assign acc = bus.in_valid && state_q == COLLECT;
  assign fire = bus.out_ready && state_q == EMIT;
  assign lt = bus.in_data != SAT && bus.in_data < min_q;
  // frame sequencing: fill buffer while tracking the minimum, then drain it
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    rd_d = rd_q;
    min_d = lt && acc ? bus.in_data : min_q;
    all_sat_d = all_sat_q;
    if (acc) begin
      wr_d = wr_q + 1'b1;
      if (wr_q == LAST) begin
        state_d = EMIT;
        wr_d = '0;
        all_sat_d = min_d == SAT;
      end
    end
    if (fire) begin
      rd_d = rd_q + 1'b1;
      if (rd_q == LAST) begin
        state_d = COLLECT;
        rd_d = '0;
        min_d = SAT;
        all_sat_d = 1'b0;
      end
    end
  end
  // control state; an asynchronous reset discards any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      wr_q <= '0;
      rd_q <= '0;
      min_q <= SAT;
      all_sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      min_q <= min_d;
      all_sat_q <= all_sat_d;
    end
  end
  // score storage needs no reset, every entry is rewritten before it is read
  always_ff @(posedge clk) begin
    if (acc) buf_q[wr_q] <= bus.in_data;
  end
  log_subtractor #(.M(M)) u_sub (.a_i(buf_q[rd_q]), .b_i(min_q), .y_o(diff));
  assign bus.in_ready = state_q == COLLECT;
  assign bus.out_valid = state_q == EMIT;
  assign bus.out_data = state_q == EMIT ? diff : '0;
  assign bus.out_idx = rd_q;
  assign bus.out_last = state_q == EMIT && rd_q == LAST;
  assign bus.all_sat = all_sat_q;
`ifdef LOG_NORM_WINNER_EN
  logic [IW-1:0] idx_q, idx_d, win_q, win_d;
  // track the lowest-index argmin and publish it when the frame closes
  always_comb begin
    idx_d = acc && lt ? wr_q : idx_q;
    win_d = win_q;
    if (acc && wr_q == LAST) begin
      win_d = idx_d;
      idx_d = '0;
    end
  end
  // argmin registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      win_q <= '0;
    end else begin
      idx_q <= idx_d;
      win_q <= win_d;
    end
  end
  assign bus.winner = win_q;
`endif
endmodule
